// File: rtl/seg_scan_if.sv
// Bundle of the processor-side load inputs and the decoder/anode-side outputs
// of the seven-segment scan controller. The master side is the value source and
// display observer; the slave side is the scan controller itself.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    // Processor side: value to show, its sign, load strobe and blanking mode.
    logic [4*NDIG-1:0] value;
    logic              neg;
    logic              load;
    logic              blank_lz;

    // Display side: decoder inputs, active-low anodes and status pulses.
    logic [3:0]        seg_bcd;
    logic              seg_neg;
    logic [NDIG:0]     an;
    logic              frame_sync;
    logic              upd_ack;

    // Handshake: load is a single-cycle strobe with no back-pressure. Every
    // cycle it is high, value/neg are captured (last one before a frame end
    // wins). upd_ack pulses for exactly one cycle after the displayed copy
    // changes, which always happens right after a frame_sync cycle.
    modport master (
        output value, neg, load, blank_lz,
        input  seg_bcd, seg_neg, an, frame_sync, upd_ack
    );

    modport slave (
        input  value, neg, load, blank_lz,
        output seg_bcd, seg_neg, an, frame_sync, upd_ack
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG hex digits plus a sign position,
// sharing one hex-to-seven-segment decoder and a common-anode digit bank.
// The displayed value lives in a shadow register that only changes at frame
// boundaries, so a frame never mixes digits of two different values.
module seg_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 50000,
    parameter int GAP      = 500
) (
    input  logic       clk,
    input  logic       reset,
    seg_scan_if.slave  bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = $clog2(NDIG + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP);
    localparam logic [IDX_W-1:0] IDX_SIGN = IDX_W'(NDIG);

    // Slot position within the frame.
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    // Cleared by reset so the anodes stay dark until scanning has restarted.
    logic              active;

    // Displayed copy of the value and the pending (loaded, not yet shown) copy.
    logic [4*NDIG-1:0] shadow_val;
    logic              shadow_neg;
    logic [4*NDIG-1:0] pend_val;
    logic              pend_neg;
    logic              pend;

    logic              upd_ack_q;
    logic              blank_lz_q;

    logic              slot_end;
    logic              frame_end;
    logic [NDIG:0]     blank;
    logic [3:0]        digit_nib;
    logic [NDIG:0]     an_c;

    assign slot_end  = (cnt >= CNT_LAST);
    assign frame_end = (idx == IDX_SIGN) && (cnt == CNT_LAST);

    // Slot counter and digit index; an out-of-range index falls back to slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (idx > IDX_SIGN) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_SIGN) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Scan-enable flag: low for the first cycle after reset so anodes stay off.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // Blanking mode register, so no input reaches the outputs combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_lz_q <= 1'b0;
        end else begin
            blank_lz_q <= bus.blank_lz;
        end
    end

    // Load capture and frame-aligned shadow update; a load on the frame-end
    // cycle bypasses the pending register and wins over an older pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val   <= '0;
            pend_neg   <= 1'b0;
            pend       <= 1'b0;
            shadow_val <= '0;
            shadow_neg <= 1'b0;
            upd_ack_q  <= 1'b0;
        end else if (frame_end) begin
            if (bus.load) begin
                shadow_val <= bus.value;
                shadow_neg <= bus.neg;
                upd_ack_q  <= 1'b1;
            end else if (pend) begin
                shadow_val <= pend_val;
                shadow_neg <= pend_neg;
                upd_ack_q  <= 1'b1;
            end else begin
                upd_ack_q  <= 1'b0;
            end
            pend <= 1'b0;
        end else begin
            upd_ack_q <= 1'b0;
            if (bus.load) begin
                pend_val <= bus.value;
                pend_neg <= bus.neg;
                pend     <= 1'b1;
            end
        end
    end

    // Blank mask: sign blanked when positive; with leading-zero blanking, a
    // digit is blanked when it and every more significant digit are zero.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_val[4*i +: 4] == 4'h0);
            blank[i]   = blank_lz_q && zero_above;
        end
        blank[NDIG] = !shadow_neg;
    end

    // Nibble of the shadow value selected by the current digit slot.
    always_comb begin
        digit_nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_nib = shadow_val[4*i +: 4];
            end
        end
    end

    // Active-low anode drive: dark during the gap and for blanked positions.
    always_comb begin
        an_c = '1;
        if (active && (cnt >= GAP_END)) begin
            for (int i = 0; i <= NDIG; i++) begin
                if ((idx == IDX_W'(i)) && !blank[i]) begin
                    an_c[i] = 1'b0;
                end
            end
        end
    end

    assign bus.an         = an_c;
    assign bus.seg_bcd    = (idx < IDX_SIGN) ? digit_nib : 4'h0;
    assign bus.seg_neg    = (idx == IDX_SIGN) && shadow_neg;
    assign bus.frame_sync = frame_end;
    assign bus.upd_ack    = upd_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NDIG=4, TICK_DIV=8, GAP=2. A frame-position
// model (cycle count since reset) plus a value/pending model gives the
// expected outputs every cycle; directed sequences pin literal values.
module tb_seg_scan_ctrl;

    localparam int NDIG     = 4;
    localparam int TICK_DIV = 8;
    localparam int GAP      = 2;
    localparam int FRAME    = (NDIG + 1) * TICK_DIV;

    logic clk;
    logic reset;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(
        .NDIG     (NDIG),
        .TICK_DIV (TICK_DIV),
        .GAP      (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fs  = -1;
    int ack_cnt  = 0;

    logic [3:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position in the frame is just the cycle count since reset; the value
    // state follows the load rules at frame end.
    int          m_t      = 0;
    logic        m_valid  = 1'b0;
    logic [15:0] m_shadow = '0;
    logic        m_neg    = 1'b0;
    logic [15:0] m_pval   = '0;
    logic        m_pneg   = 1'b0;
    logic        m_pend   = 1'b0;
    logic        m_ack    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_t = 0; m_valid = 1'b1;
            m_shadow = '0; m_neg = 1'b0;
            m_pval = '0; m_pneg = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
        end else if (m_valid) begin
            m_ack = 1'b0;
            if (m_t % FRAME == FRAME - 1) begin
                if (bus.load) begin
                    m_shadow = bus.value; m_neg = bus.neg; m_ack = 1'b1;
                end else if (m_pend) begin
                    m_shadow = m_pval; m_neg = m_pneg; m_ack = 1'b1;
                end
                m_pend = 1'b0;
            end else if (bus.load) begin
                m_pval = bus.value; m_pneg = bus.neg; m_pend = 1'b1;
            end
            m_t++;
        end
    end

    function automatic int m_cnt();
        return m_t % TICK_DIV;
    endfunction

    function automatic int m_idx();
        return (m_t / TICK_DIV) % (NDIG + 1);
    endfunction

    function automatic int exp_an();
        int i;
        i = m_idx();
        if (m_cnt() < GAP) return 5'h1F;
        if (i == NDIG) return m_neg ? (5'h1F & ~(1 << NDIG)) : 5'h1F;
        if (i >= 1 && bus.blank_lz && ((m_shadow >> (4 * i)) == 16'h0)) return 5'h1F;
        return 5'h1F & ~(1 << i);
    endfunction

    function automatic int exp_bcd();
        if (m_idx() == NDIG) return 0;
        return int'((m_shadow >> (4 * m_idx())) & 16'hF);
    endfunction

    function automatic int exp_neg();
        return (m_idx() == NDIG) ? int'(m_neg) : 0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            check("an",         int'(bus.an),         exp_an());
            check("seg_bcd",    int'(bus.seg_bcd),    exp_bcd());
            check("seg_neg",    int'(bus.seg_neg),    exp_neg());
            check("frame_sync", int'(bus.frame_sync), int'(m_t % FRAME == FRAME - 1));
            check("upd_ack",    int'(bus.upd_ack),    int'(m_ack));
            check("an_onehot",  int'($countones(~bus.an) <= 1), 1);
            if (bus.upd_ack) ack_cnt++;
            if (reset) begin
                last_fs = -1;
            end else if (bus.frame_sync) begin
                if (last_fs >= 0) check("fs_period", cyc - last_fs, FRAME);
                last_fs = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pos(input int i, input int c);
        for (int k = 0; k < 4 * FRAME; k++) begin
            @(negedge clk);
            if (m_idx() == i && m_cnt() == c) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_pos: slot %0d cnt %0d not reached", i, c);
    endtask

    // Called at a negedge; holds load for exactly one rising edge.
    task automatic pulse_load(input logic [15:0] v, input logic n);
        bus.value = v;
        bus.neg   = n;
        bus.load  = 1'b1;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        logic [15:0] rv;
        reset        = 1'b1;
        bus.value    = '0;
        bus.neg      = 1'b0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_an",      int'(bus.an),         5'h1F);
        check("rst_bcd",     int'(bus.seg_bcd),    0);
        check("rst_neg",     int'(bus.seg_neg),    0);
        check("rst_fs",      int'(bus.frame_sync), 0);
        check("rst_ack",     int'(bus.upd_ack),    0);
        reset = 1'b0;

        // 1: basic scan of 12AF
        pulse_load(16'h12AF, 1'b0);
        wait_pos(0, 0);
        check("t1_ack", int'(bus.upd_ack), 1);
        exp_q.push_back(4'hF); exp_q.push_back(4'hA);
        exp_q.push_back(4'h2); exp_q.push_back(4'h1);
        for (int s = 0; s < NDIG; s++) begin
            wait_pos(s, 2);
            check("t1_bcd", int'(bus.seg_bcd), int'(exp_q.pop_front()));
            check("t1_an",  int'(bus.an),      5'h1F & ~(1 << s));
        end
        wait_pos(0, 7);
        check("t1_slot0_end", int'(bus.an), 5'b11110);
        wait_pos(4, 3);
        check("t1_sign_an", int'(bus.an), 5'h1F);
        wait_pos(4, 6);
        check("t1_fs_lo", int'(bus.frame_sync), 0);
        wait_pos(4, 7);
        check("t1_fs_hi", int'(bus.frame_sync), 1);

        // 2: negative value with leading-zero blanking
        wait_pos(1, 0);
        bus.blank_lz = 1'b1;
        pulse_load(16'h0003, 1'b1);
        wait_pos(0, 0);
        check("t2_ack", int'(bus.upd_ack), 1);
        wait_pos(0, 3);
        check("t2_d0_an",  int'(bus.an),      5'b11110);
        check("t2_d0_bcd", int'(bus.seg_bcd), 3);
        wait_pos(1, 4); check("t2_d1_an", int'(bus.an), 5'h1F);
        wait_pos(2, 4); check("t2_d2_an", int'(bus.an), 5'h1F);
        wait_pos(3, 4); check("t2_d3_an", int'(bus.an), 5'h1F);
        wait_pos(4, 2);
        check("t2_sign_an",  int'(bus.an),      5'b01111);
        check("t2_sign_neg", int'(bus.seg_neg), 1);
        check("t2_sign_bcd", int'(bus.seg_bcd), 0);

        // 3: frame-aligned update
        wait_pos(4, 0);
        bus.blank_lz = 1'b0;
        wait_pos(0, 1);
        pulse_load(16'h1111, 1'b0);
        wait_pos(0, 0);
        wait_pos(1, 3);
        a0 = ack_cnt;
        pulse_load(16'h2222, 1'b0);
        wait_pos(2, 3);
        check("t3_old", int'(bus.seg_bcd), 1);
        wait_pos(0, 0);
        check("t3_ack_hi", int'(bus.upd_ack), 1);
        wait_pos(0, 1);
        check("t3_ack_lo", int'(bus.upd_ack), 0);
        wait_pos(0, 2);
        check("t3_new", int'(bus.seg_bcd), 2);
        wait_pos(0, 3);
        wait_pos(0, 3);
        check("t3_one_ack", ack_cnt - a0, 1);

        // 4: pending value overridden by a load on the frame_sync cycle
        wait_pos(1, 1);
        pulse_load(16'h3333, 1'b0);
        wait_pos(4, 7);
        a0 = ack_cnt;
        pulse_load(16'h4444, 1'b0);
        wait_pos(0, 0);
        check("t4_ack", int'(bus.upd_ack), 1);
        wait_pos(0, 2); check("t4_d0", int'(bus.seg_bcd), 4);
        wait_pos(2, 2); check("t4_d2", int'(bus.seg_bcd), 4);
        wait_pos(0, 0);
        check("t4_no_ack", int'(bus.upd_ack), 0);
        wait_pos(0, 3);
        check("t4_one_ack", ack_cnt - a0, 1);

        // 5: reset mid-frame with a load pending
        wait_pos(0, 4);
        pulse_load(16'h5555, 1'b1);
        wait_pos(2, 3);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_an",  int'(bus.an),      5'h1F);
        check("t5_rst_ack", int'(bus.upd_ack), 0);
        @(negedge clk);
        check("t5_rst_an2", int'(bus.an),      5'h1F);
        reset = 1'b0;
        wait_pos(0, 2);
        check("t5_d0_an",  int'(bus.an),      5'b11110);
        check("t5_d0_bcd", int'(bus.seg_bcd), 0);
        wait_pos(1, 2); check("t5_d1_bcd", int'(bus.seg_bcd), 0);
        wait_pos(4, 3);
        check("t5_sign_an",  int'(bus.an),      5'h1F);
        check("t5_sign_neg", int'(bus.seg_neg), 0);
        wait_pos(0, 0);
        check("t5_no_ack", int'(bus.upd_ack), 0);

        // 6: gap timing over a frame with every position lit
        wait_pos(0, 1);
        pulse_load(16'h9876, 1'b1);
        wait_pos(4, 7);
        for (int s = 0; s <= NDIG; s++) begin
            int off;
            off = 0;
            for (int c = 0; c < TICK_DIV; c++) begin
                @(negedge clk);
                if (bus.an == 5'h1F) off++;
                check("t6_gap_pos", int'(bus.an == 5'h1F), int'(c < GAP));
            end
            check("t6_gap_len", off, GAP);
        end

        // Random phase: loads at random times, blanking changes at slot starts.
        for (int k = 0; k < 1600; k++) begin
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                rv        = 16'($urandom);
                rv        = rv >> (4 * $urandom_range(0, 4));
                bus.value = rv;
                bus.neg   = 1'($urandom_range(0, 1));
                bus.load  = 1'b1;
            end
            if (m_cnt() == 0 && $urandom_range(0, 3) == 0) begin
                bus.blank_lz = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
